// File: rtl/adc_convst_pulse_gen.sv
// adc_convst_pulse_gen
// Periodic ADC conversion-start strobe generator. It divides the sample clock
// into a programmable period and high time, and runs either continuously or
// for a fixed-length burst. A run always starts with a full high phase and
// always stops on a period boundary, so it never produces a runt pulse.
//
// Optional build macro: CONVST_SYNC_EN
//   When it is defined, the block gets a 'sync' input. A rising edge on 'sync'
//   while busy restarts the period so that the strobe follows an external
//   reference such as PPS. When it is undefined, there is no port and no
//   resync logic.
module adc_convst_pulse_gen #(
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned HIGH_WIDTH  = 8,
  parameter int unsigned BURST_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [DIV_WIDTH-1:0]   period,
  input  logic [HIGH_WIDTH-1:0]  high_cycles,
  input  logic [BURST_WIDTH-1:0] burst_count,
`ifdef CONVST_SYNC_EN
  input  logic                   sync,
`endif
  output logic                   sig,
  output logic                   busy,
  output logic                   done
);

  // Common width for comparing the period against the high time.
  localparam int unsigned CW = (DIV_WIDTH > HIGH_WIDTH) ? DIV_WIDTH : HIGH_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  state_t                 state;

  // Run parameters captured at start; inputs are ignored while busy.
  logic [DIV_WIDTH-1:0]   p_sh;
  logic [DIV_WIDTH-1:0]   h_sh;
  logic [BURST_WIDTH-1:0] burst_sh;

  // 1-based position within the current period, and pulses issued this run.
  logic [DIV_WIDTH-1:0]   pcnt;
  logic [BURST_WIDTH-1:0] pulse_cnt;

  logic [CW-1:0]          period_ext;
  logic [CW-1:0]          high_ext;
  logic [CW-1:0]          p_clamp;
  logic [CW-1:0]          h_clamp;

  logic                   high_end;
  logic                   period_end;
  logic                   burst_hit;
  logic [BURST_WIDTH-1:0] pulse_next;
  logic                   sync_rise;

  // Clamp the requested timing to a legal pulse: P >= 2 and 1 <= H <= P-1.
  always_comb begin
    period_ext = CW'(period);
    high_ext   = CW'(high_cycles);
    p_clamp    = (period_ext < CW'(2)) ? CW'(2) : period_ext;
    if (high_ext == '0) begin
      h_clamp = CW'(1);
    end else if (high_ext >= p_clamp) begin
      h_clamp = p_clamp - CW'(1);
    end else begin
      h_clamp = high_ext;
    end
  end

  // Phase boundaries, the burst limit and the saturating pulse count.
  always_comb begin
    high_end   = (pcnt == h_sh);
    period_end = (pcnt == p_sh);
    burst_hit  = (burst_sh != '0) && (pulse_cnt >= burst_sh);
    if (burst_sh == '0) begin
      pulse_next = '0;
    end else if (pulse_cnt == {BURST_WIDTH{1'b1}}) begin
      pulse_next = pulse_cnt;
    end else begin
      pulse_next = pulse_cnt + BURST_WIDTH'(1);
    end
  end

`ifdef CONVST_SYNC_EN
  logic sync_q;

  // Keep the previous sync sample so that a rising edge can be detected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 1'b0;
    end else begin
      sync_q <= sync;
    end
  end

  assign sync_rise = sync & ~sync_q;
`else
  assign sync_rise = 1'b0;
`endif

  // Strobe FSM: IDLE -> HIGH (H clocks) -> LOW (P-H clocks) -> HIGH or IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      sig       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      p_sh      <= '0;
      h_sh      <= '0;
      burst_sh  <= '0;
      pcnt      <= '0;
      pulse_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en) begin
            p_sh      <= DIV_WIDTH'(p_clamp);
            h_sh      <= DIV_WIDTH'(h_clamp);
            burst_sh  <= burst_count;
            pcnt      <= DIV_WIDTH'(1);
            pulse_cnt <= (burst_count == '0) ? '0 : BURST_WIDTH'(1);
            state     <= ST_HIGH;
            sig       <= 1'b1;
            busy      <= 1'b1;
          end
        end

        ST_HIGH: begin
          if (sync_rise) begin
            // A reference edge starts a fresh pulse immediately.
            pcnt      <= DIV_WIDTH'(1);
            pulse_cnt <= pulse_next;
            sig       <= 1'b1;
          end else if (high_end) begin
            pcnt  <= pcnt + DIV_WIDTH'(1);
            state <= ST_LOW;
            sig   <= 1'b0;
          end else begin
            pcnt <= pcnt + DIV_WIDTH'(1);
          end
        end

        ST_LOW: begin
          if (period_end) begin
            // A stop or the burst end takes priority over continuing or resyncing.
            if (!en || burst_hit) begin
              state     <= ST_IDLE;
              sig       <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              pcnt      <= '0;
              pulse_cnt <= '0;
            end else begin
              state     <= ST_HIGH;
              sig       <= 1'b1;
              pcnt      <= DIV_WIDTH'(1);
              pulse_cnt <= pulse_next;
            end
          end else if (sync_rise) begin
            state     <= ST_HIGH;
            sig       <= 1'b1;
            pcnt      <= DIV_WIDTH'(1);
            pulse_cnt <= pulse_next;
          end else begin
            pcnt <= pcnt + DIV_WIDTH'(1);
          end
        end

        default: begin
          state     <= ST_IDLE;
          sig       <= 1'b0;
          busy      <= 1'b0;
          pcnt      <= '0;
          pulse_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_convst_pulse_gen.sv
// Testbench for adc_convst_pulse_gen: directed scenarios plus randomized runs,
// all checked every clock against a behavioural model of the strobe timing.
module tb_adc_convst_pulse_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [15:0] period = '0;
  logic [7:0]  high_cycles = '0;
  logic [15:0] burst_count = '0;
`ifdef CONVST_SYNC_EN
  logic        sync = 1'b0;
`endif
  logic        sig;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model state: running flag, clamped P/H, burst, offset in period, pulses issued.
  bit   m_run = 1'b0;
  int   mp = 2;
  int   mh = 1;
  int   mb = 0;
  int   mk = 0;
  int   mm = 0;
  bit   m_sync_prev = 1'b0;
  logic e_sig  = 1'b0;
  logic e_busy = 1'b0;
  logic e_done = 1'b0;

  adc_convst_pulse_gen #(
    .DIV_WIDTH  (16),
    .HIGH_WIDTH (8),
    .BURST_WIDTH(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .period     (period),
    .high_cycles(high_cycles),
    .burst_count(burst_count),
`ifdef CONVST_SYNC_EN
    .sync       (sync),
`endif
    .sig        (sig),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b cycle=%0d", tag, obs, expv, cyc);
    end
  endtask

  // Reference behaviour at one rising clock edge, using the inputs that were sampled.
  task automatic model_edge();
    bit srise;
    srise = 1'b0;
`ifdef CONVST_SYNC_EN
    srise = sync && !m_sync_prev;
    m_sync_prev = sync;
`endif
    e_done = 1'b0;
    if (!m_run) begin
      if (en) begin
        m_run = 1'b1;
        mp = (period < 16'd2) ? 2 : int'(period);
        mh = int'(high_cycles);
        if (mh == 0) mh = 1;
        else if (mh >= mp) mh = mp - 1;
        mb = int'(burst_count);
        mk = 0;
        mm = 1;
      end
    end else if (mk + 1 == mp) begin
      if (!en || (mb != 0 && mm >= mb)) begin
        m_run  = 1'b0;
        e_done = 1'b1;
      end else begin
        mk = 0;
        mm++;
      end
    end else if (srise) begin
      mk = 0;
      mm++;
    end else begin
      mk++;
    end
    e_sig  = m_run && (mk < mh);
    e_busy = m_run;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    chk("sig", sig, e_sig);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_cfg(input int p, input int h, input int b);
    period      = 16'(p);
    high_cycles = 8'(h);
    burst_count = 16'(b);
  endtask

  // Drop the run request and allow the current period to finish (bounded).
  task automatic drain();
    en = 1'b0;
`ifdef CONVST_SYNC_EN
    sync = 1'b0;
`endif
    for (int i = 0; i < 300 && m_run; i++) step();
    step();
    chk("drain_idle", busy, 1'b0);
  endtask

  initial begin
    // Reset state.
    @(posedge clk);
    #1;
    chk("rst_sig", sig, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    #2 rst = 1'b0;

    // Continuous run with P=10 and H=3.
    set_cfg(10, 3, 0);
    en = 1'b1;
    step();
    chk("first_rise", sig, 1'b1);
    steps(35);
    drain();

    // A burst of 4 pulses with P=8 and H=2; new inputs take effect only on re-arm.
    set_cfg(8, 2, 4);
    en = 1'b1;
    step();
    set_cfg(6, 1, 1);
    steps(31);
    step();
    chk("burst_done", done, 1'b1);
    chk("burst_sig0", sig, 1'b0);
    step();
    chk("rearm_rise", sig, 1'b1);
    steps(20);
    drain();

    // Clamping cases: P=1 with H=0, then P=5 with H=9.
    set_cfg(1, 0, 0);
    en = 1'b1;
    steps(10);
    drain();
    set_cfg(5, 9, 0);
    en = 1'b1;
    steps(12);
    drain();

    // Drop the run request 2 clocks into HIGH; the period still completes.
    set_cfg(10, 5, 0);
    en = 1'b1;
    step();
    steps(2);
    en = 1'b0;
    steps(7);
    chk("no_runt_busy", busy, 1'b1);
    drain();

    // Assert async reset mid-HIGH, then release with the run request held.
    set_cfg(10, 5, 0);
    en = 1'b1;
    steps(3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_sig", sig, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    m_run = 1'b0;
    m_sync_prev = 1'b0;
    e_sig = 1'b0;
    e_busy = 1'b0;
    e_done = 1'b0;
    #1 rst = 1'b0;
    steps(25);
    drain();

`ifdef CONVST_SYNC_EN
    // A sync edge 7 clocks after a rise restarts the period with P=20.
    set_cfg(20, 5, 0);
    en = 1'b1;
    step();
    steps(7);
    sync = 1'b1;
    step();
    chk("sync_restart", sig, 1'b1);
    sync = 1'b0;
    steps(45);
    drain();
`endif

    // Randomized runs in which inputs change while busy and en toggles.
    for (int r = 0; r < 40; r++) begin
      int len;
      set_cfg($urandom_range(0, 12), $urandom_range(0, 14), $urandom_range(0, 4));
      en  = 1'b1;
      len = $urandom_range(5, 60);
      for (int i = 0; i < len; i++) begin
        step();
        set_cfg($urandom_range(0, 12), $urandom_range(0, 14), $urandom_range(0, 4));
        if ($urandom_range(0, 15) == 0) en = !en;
`ifdef CONVST_SYNC_EN
        sync = ($urandom_range(0, 19) == 0);
`endif
      end
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
